sat_addsub_seq: RTL and testbench
=================================

SAT_ADDSUB_SEQ -- requirements
Module: sat_addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width; legal values are multiples of 4 that are at least 4.
REQ-002 SHALL have localparam NSLICE = WIDTH/4: number of 4-bit slices processed, one per cycle.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand request.
REQ-006 SHALL have port in_ready, output, 1 bit: unit can accept operands.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: two's-complement operands.
REQ-008 SHALL have port sub, input, 1 bit: 0 computes a+b; 1 computes a-b.
REQ-009 SHALL have port sat_mode, input, 1 bit: 1 saturates on overflow; 0 wraps.
REQ-010 SHALL have port out_valid, output, 1 bit: result available.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port result, output, WIDTH bits: final sum or difference.
REQ-013 SHALL have port cout, output, 1 bit: raw carry out of the MSB.
REQ-014 SHALL have port ovf, output, 1 bit: signed overflow of this operation.
REQ-015 SHALL have port ovf_sticky, output, 1 bit: accumulated overflow flag.
REQ-016 SHALL have port clr_sticky, input, 1 bit: synchronous clear of ovf_sticky.

Function
REQ-017 SHALL implement an FSM with states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 SHALL, when in_valid=1 and in_ready=1, capture a, b^{WIDTH{sub}}, sub and sat_mode, clear the slice index to 0, load the carry register with sub, and enter BUSY; changes to the inputs afterwards SHALL have no effect on that operation.
REQ-019 SHALL, in BUSY, process slice k (bits 4k+3..4k) in cycle k using a 4-bit carry-lookahead (P = A^B', G = A&B'), write the slice sum, and register its carry-out as the carry-in of slice k+1.
REQ-020 SHALL, on the last slice (k = NSLICE-1), enter DONE, so that out_valid rises exactly NSLICE rising edges after the accepting edge.
REQ-021 SHALL set overflow when A[MSB]=B'[MSB] and raw[MSB]!=A[MSB], evaluated on the final slice; ovf is independent of sat_mode.
REQ-022 SHALL output the saturated value when saturation was captured and overflow occurred: positive overflow gives 0 followed by WIDTH-1 ones (e.g. 0x7FFF); negative overflow gives 1 followed by WIDTH-1 zeros (e.g. 0x8000); otherwise result is the raw sum.
REQ-023 SHALL set cout to the unsaturated carry out of bit WIDTH-1 in all modes.
REQ-024 SHALL, in DONE, hold result, cout, ovf and out_valid=1 stable until out_ready=1.
REQ-025 SHALL return to IDLE on the edge where out_valid=1 and out_ready=1; in_ready SHALL become 1 in the following cycle, so there is no same-cycle re-accept.
REQ-026 SHALL set ovf_sticky on the edge entering DONE with overflow, and clear it on any edge with clr_sticky=1; when both occur on the same edge, the set SHALL win.
REQ-027 SHALL ignore in_valid while in BUSY or DONE.

Reset
REQ-028 SHALL, when rst=1, immediately and asynchronously set: state to IDLE, in_ready=1, out_valid=0, result=0, cout=0, ovf=0, ovf_sticky=0, slice index=0, carry=0.
REQ-029 SHALL abandon any in-flight BUSY or DONE operation on reset; no result from it is ever presented.

Verification (WIDTH=16, NSLICE=4)
REQ-030 SHALL cover: 0x7FFF+0x0001 with sat_mode=1 -> result 0x7FFF, ovf=1, cout=0, out_valid 4 edges after accept, ovf_sticky=1.
REQ-031 SHALL cover: 0x7FFF+0x0001 with sat_mode=0 -> result 0x8000, ovf=1, cout=0.
REQ-032 SHALL cover: 0x8000-0x0001 with sat_mode=1 -> result 0x8000, ovf=1, cout=1; the same with sat_mode=0 -> result 0x7FFF.
REQ-033 SHALL cover: 0x1234-0x1234 -> result 0x0000, cout=1, ovf=0; then clr_sticky pulsed on the same edge as an overflowing completion -> ovf_sticky stays 1.
REQ-034 SHALL cover: out_ready=0 for 3 cycles in DONE -> result and flags stable, in_ready=0, in_valid ignored; then out_ready=1 -> in_ready=1 one cycle later.
REQ-035 SHALL cover: rst pulsed during BUSY slice 2 -> out_valid=0 and in_ready=1 during and after reset, outputs 0, and the next operation (0x0003+0x0004) yields 0x0007.

Source files
------------

// File: rtl/sat_addsub_seq.sv
// sat_addsub_seq: serial saturating add/subtract, one 4-bit carry-lookahead slice per cycle.
// Valid/ready on both sides; a sticky overflow flag accumulates across operations.
module sat_addsub_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             sat_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             ovf_sticky,
   input  logic             clr_sticky
);
   localparam int NSLICE = WIDTH / 4;
   localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, raw;
   logic [IW-1:0] idx_q, idx_d;
   logic sat_q, sat_d, c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, sticky_q, sticky_d;
   logic [3:0] sa, sb, p, g, sum;
   logic c1, c2, c3, c4, last, of;
   logic [IW+1:0] lsb;
   assign lsb = {idx_q, 2'b00};
   assign sa = a_q[lsb +: 4];
   assign sb = b_q[lsb +: 4];
   assign p = sa ^ sb;
   assign g = sa & sb;
   // Flattened lookahead carries; c4 feeds the next slice
   assign c1 = g[0] | (p[0] & c_q);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
   assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & c_q);
   assign sum = p ^ {c3, c2, c1, c_q};
   assign last = idx_q == IW'(NSLICE - 1);
   always_comb begin
      raw = res_q;
      raw[lsb +: 4] = sum;
   end
   assign of = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw[WIDTH-1] != a_q[WIDTH-1]);
   always_comb begin
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      sat_d = sat_q;
      idx_d = idx_q;
      c_d = c_q;
      res_d = res_q;
      cout_d = cout_q;
      ovf_d = ovf_q;
      sticky_d = sticky_q & ~clr_sticky;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = BUSY;
            a_d = a;
            b_d = b ^ {WIDTH{sub}};
            sat_d = sat_mode;
            idx_d = '0;
            c_d = sub;
         end
         BUSY: begin
            res_d = raw;
            c_d = c4;
            idx_d = idx_q + 1'b1;
            if (last) begin
               state_d = DONE;
               res_d = (sat_q && of) ? (a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : raw;
               cout_d = c4;
               ovf_d = of;
               sticky_d = sticky_d | of;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         sat_q <= 1'b0;
         idx_q <= '0;
         c_q <= 1'b0;
         res_q <= '0;
         cout_q <= 1'b0;
         ovf_q <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         sat_q <= sat_d;
         idx_q <= idx_d;
         c_q <= c_d;
         res_q <= res_d;
         cout_q <= cout_d;
         ovf_q <= ovf_d;
         sticky_q <= sticky_d;
      end
   end
   assign in_ready = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign result = res_q;
   assign cout = cout_q;
   assign ovf = ovf_q;
   assign ovf_sticky = sticky_q;
endmodule

// File: tb/tb_sat_addsub_seq.sv
// tb_sat_addsub_seq: directed and random operations against a signed-integer reference model.
module tb_sat_addsub_seq;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sub = 1'b0, sat_mode = 1'b0;
   logic out_ready = 1'b0, clr_sticky = 1'b0;
   logic in_ready, out_valid, cout, ovf, ovf_sticky;
   logic [15:0] a = '0, b = '0, result;
   int checks = 0, errors = 0;
   logic sticky_m = 1'b0;
   sat_addsub_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .sub(sub), .sat_mode(sat_mode), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .cout(cout), .ovf(ovf), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
   );
   always #5 clk = ~clk;
   // Returns {ovf, cout, result} from exact signed arithmetic plus an unsigned carry sum
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s, input logic st);
      int sx, sy, r;
      logic [16:0] u;
      logic o;
      logic [15:0] res;
      sx = int'($signed(x));
      sy = int'($signed(y));
      r = s ? sx - sy : sx + sy;
      u = {1'b0, x} + {1'b0, (s ? ~y : y)} + {16'd0, s};
      o = (r > 32767) || (r < -32768);
      res = (st && o) ? ((r > 0) ? 16'h7FFF : 16'h8000) : u[15:0];
      return {o, u[16], res};
   endfunction
   task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s, input logic st,
                         input logic clr_done, input int hold);
      logic [17:0] e;
      int cyc;
      e = model(x, y, s, st);
      cyc = 0;
      while (!in_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
      @(negedge clk);
      a = x; b = y; sub = s; sat_mode = st; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); sat_mode = 1'($urandom);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         if (clr_done && cyc == 3) clr_sticky = 1'b1;
         @(posedge clk); #1;
         clr_sticky = 1'b0;
         cyc++;
      end
      sticky_m = e[17] ? 1'b1 : (clr_done ? 1'b0 : sticky_m);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL latency got %0d want 4", cyc); end
      checks++; if (result !== e[15:0]) begin errors++; $display("FAIL result %h%s%h s=%b sat=%b got %h want %h", x, s ? "-" : "+", y, s, st, result, e[15:0]); end
      checks++; if (cout !== e[16]) begin errors++; $display("FAIL cout %h,%h s=%b got %b want %b", x, y, s, cout, e[16]); end
      checks++; if (ovf !== e[17]) begin errors++; $display("FAIL ovf %h,%h s=%b got %b want %b", x, y, s, ovf, e[17]); end
      checks++; if (ovf_sticky !== sticky_m) begin errors++; $display("FAIL sticky got %b want %b", ovf_sticky, sticky_m); end
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e[15:0] || cout !== e[16] || ovf !== e[17]) begin
            errors++;
            $display("FAIL hold%0d got v=%b r=%b res=%h c=%b o=%b want v=1 r=0 res=%h c=%b o=%b",
                     i, out_valid, in_ready, result, cout, ovf, e[15:0], e[16], e[17]);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
   endtask
   task automatic test_reset;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0 || ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL reset got r=%b v=%b res=%h c=%b o=%b st=%b want r=1 v=0 res=0000 c=0 o=0 st=0", in_ready, out_valid, result, cout, ovf, ovf_sticky);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
   endtask
   task automatic test_directed;
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
      run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 0);
      run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 0);
      run_op(16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0, 0);
      run_op(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
      run_op(16'h0000, 16'h8000, 1'b1, 1'b1, 1'b0, 0);
   endtask
   task automatic test_sticky_clear;
      @(negedge clk); clr_sticky = 1'b1;
      @(posedge clk); #1; clr_sticky = 1'b0; sticky_m = 1'b0;
      checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clr got %b want 0", ovf_sticky); end
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 0);
      run_op(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1, 0);
   endtask
   task automatic test_backpressure;
      run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 3);
      run_op(16'h4000, 16'h3000, 1'b0, 1'b0, 1'b0, 3);
   endtask
   task automatic test_random;
      logic [15:0] x, y;
      for (int n = 0; n < 40; n++) begin
         x = (n % 5 == 0) ? 16'h7FFF : 16'($urandom);
         y = (n % 7 == 0) ? 16'h8000 : 16'($urandom);
         run_op(x, y, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
      end
   endtask
   task automatic test_reset_midop;
      @(negedge clk);
      a = 16'h7FFF; b = 16'h0001; sub = 1'b0; sat_mode = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b1; #1;
      sticky_m = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0 || ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL midop_rst got v=%b r=%b res=%h c=%b o=%b st=%b want v=0 r=1 res=0000 c=0 o=0 st=0", out_valid, in_ready, result, cout, ovf, ovf_sticky);
      end
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL post_rst got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
      end
      run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 0);
      checks++; if (result !== 16'h0007) begin errors++; $display("FAIL after_rst_sum got %h want 0007", result); end
   endtask
   initial begin
      test_reset;
      test_directed;
      test_sticky_clear;
      test_backpressure;
      test_random;
      test_reset_midop;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
